// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM pipeline stage: load/store unit over a req/ack data bus
//
// Purpose
//    Takes the EX_MEM bundle, performs byte/half/word loads and stores over a
//    single-outstanding req/ack data-memory bus, and registers the MEM_WB bundle
//    for write_back. Upstream is stalled while a bus access is in flight.
//    Misaligned accesses, illegal funct3 codes and bus timeouts complete with
//    MEM_WB_err=1 and no register write.
//
// Port summary
//    clk, rst            clock (rising edge), asynchronous active-low reset
//    EX_MEM_*            incoming instruction bundle (held stable while mem_stall=1)
//    mem_stall           upstream hold request
//    dmem_req/we/addr/be/wdata, dmem_rdata/ack
//                        data-memory bus; req held until ack or timeout
//    MEM_WB_*            registered outgoing bundle for write_back

module mem_stage_lsu #(
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_MEM_valid,
   input  logic [31:0] EX_MEM_ALU_OUT,
   input  logic [31:0] EX_MEM_writedata,
   input  logic [4:0]  EX_MEM_RD,
   input  logic [2:0]  EX_MEM_funct3,
   input  logic        EX_MEM_memwrite_en,
   input  logic        EX_MEM_regwrite_en,
   input  logic        EX_MEM_wb_sel,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        MEM_WB_valid,
   output logic [4:0]  MEM_WB_RD,
   output logic        MEM_WB_regwrite_en,
   output logic        MEM_WB_wb_sel,
   output logic [31:0] MEM_WB_ALU_OUT,
   output logic [31:0] MEM_WB_LOAD_ALU_OUT,
   output logic        MEM_WB_err
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   // r_cnt holds the number of WAIT cycles already completed, so the abort
   // fires in the last allowed WAIT cycle (req high exactly TIMEOUT_CYC cycles).
   localparam bit               TO_EN     = (TIMEOUT_CYC != 0);
   localparam int               TO_LAST_I = TO_EN ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;

   logic        r_dmem_we;
   logic [31:0] r_dmem_addr;
   logic [3:0]  r_dmem_be;
   logic [31:0] r_dmem_wdata;

   logic        r_wb_valid;
   logic [4:0]  r_wb_rd;
   logic        r_wb_rw;
   logic        r_wb_sel;
   logic [31:0] r_wb_alu;
   logic [31:0] r_wb_ld;
   logic        r_wb_err;

   logic        w_is_store;
   logic        w_is_load;
   logic        w_mem_op;
   logic        w_misalign;
   logic        w_illegal;
   logic        w_bad;
   logic        w_start;
   logic        w_timeout;

   logic        w_stall;
   logic        w_req;
   logic        w_wb_live;
   logic        w_wb_err;
   logic        w_wb_rdok;
   logic        w_cnt_run;

   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_ld_data;

   // ---------------------------------------------------------------- decode
   // A store wins if both memwrite_en and wb_sel are set.
   assign w_is_store = EX_MEM_memwrite_en;
   assign w_is_load  = EX_MEM_wb_sel & ~EX_MEM_memwrite_en;
   assign w_mem_op   = EX_MEM_valid & (EX_MEM_memwrite_en | EX_MEM_wb_sel);

   assign w_misalign = ((EX_MEM_funct3[1:0] == 2'b01) & EX_MEM_ALU_OUT[0]) |
                       ((EX_MEM_funct3[1:0] == 2'b10) & (EX_MEM_ALU_OUT[1:0] != 2'b00));

   always_comb begin
      w_illegal = 1'b0;
      if (w_is_store) begin
         w_illegal = (EX_MEM_funct3 >= 3'b011);
      end else begin
         case (EX_MEM_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            default:                w_illegal = 1'b0;
         endcase
      end
   end

   assign w_bad     = w_misalign | w_illegal;
   assign w_start   = w_mem_op & ~w_bad;
   assign w_timeout = TO_EN && (r_cnt == TO_LAST);

   // ------------------------------------------------------- store lanes
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = 32'h0000_0000;
      case (EX_MEM_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << EX_MEM_ALU_OUT[1:0];
            w_wdata = {4{EX_MEM_writedata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << {EX_MEM_ALU_OUT[1], 1'b0};
            w_wdata = {2{EX_MEM_writedata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = EX_MEM_writedata;
         end
      endcase
   end

   // -------------------------------------------------------- load lanes
   // EX_MEM is held stable during WAIT, so the address/funct3 seen with the
   // ack are still those of the access in flight.
   always_comb begin
      w_ld_byte = 8'h00;
      case (EX_MEM_ALU_OUT[1:0])
         2'b00: w_ld_byte = dmem_rdata[7:0];
         2'b01: w_ld_byte = dmem_rdata[15:8];
         2'b10: w_ld_byte = dmem_rdata[23:16];
         default: w_ld_byte = dmem_rdata[31:24];
      endcase
      w_ld_half = EX_MEM_ALU_OUT[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (EX_MEM_funct3)
         3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'b010:  w_ld_data = dmem_rdata;
         3'b100:  w_ld_data = {24'h00_0000, w_ld_byte};
         3'b101:  w_ld_data = {16'h0000, w_ld_half};
         default: w_ld_data = 32'h0000_0000;
      endcase
   end

   // -------------------------------------------------------- FSM: state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------- FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_state_nxt = S_WAIT;
         S_WAIT: if (dmem_ack || w_timeout) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ FSM: outputs
   // w_wb_live selects whether MEM_WB loads a live instruction or a bubble
   // on the coming edge; it is 0 while an access is still outstanding.
   always_comb begin
      w_stall   = 1'b0;
      w_req     = 1'b0;
      w_wb_live = 1'b0;
      w_wb_err  = 1'b0;
      w_wb_rdok = 1'b0;
      w_cnt_run = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_stall = 1'b1;
            end else begin
               w_wb_live = EX_MEM_valid;
               w_wb_err  = w_mem_op & w_bad;
            end
         end
         S_WAIT: begin
            w_req = 1'b1;
            if (dmem_ack) begin
               w_wb_live = 1'b1;
               w_wb_rdok = 1'b1;
            end else if (w_timeout) begin
               w_wb_live = 1'b1;
               w_wb_err  = 1'b1;
            end else begin
               w_stall   = 1'b1;
               w_cnt_run = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Stall is gated by reset so every output reads 0 while rst is low.
   assign mem_stall = w_stall & rst;
   assign dmem_req  = w_req;

   // ------------------------------------------------------ timeout count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_cnt_run) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   // ------------------------------------------------------ bus registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= 32'h0000_0000;
         r_dmem_be    <= 4'b0000;
         r_dmem_wdata <= 32'h0000_0000;
      end else if ((r_state == S_IDLE) && w_start) begin
         r_dmem_we    <= w_is_store;
         r_dmem_addr  <= {EX_MEM_ALU_OUT[31:2], 2'b00};
         r_dmem_be    <= w_be;
         r_dmem_wdata <= w_is_store ? w_wdata : 32'h0000_0000;
      end
   end

   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_be    = r_dmem_be;
   assign dmem_wdata = r_dmem_wdata;

   // --------------------------------------------------- MEM_WB registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= 5'd0;
         r_wb_rw    <= 1'b0;
         r_wb_sel   <= 1'b0;
         r_wb_alu   <= 32'h0000_0000;
         r_wb_ld    <= 32'h0000_0000;
         r_wb_err   <= 1'b0;
      end else begin
         r_wb_valid <= w_wb_live;
         r_wb_rd    <= w_wb_live ? EX_MEM_RD : 5'd0;
         r_wb_rw    <= w_wb_live & EX_MEM_regwrite_en & ~w_is_store & ~w_wb_err;
         r_wb_sel   <= w_wb_live & EX_MEM_wb_sel;
         r_wb_alu   <= w_wb_live ? EX_MEM_ALU_OUT : 32'h0000_0000;
         r_wb_ld    <= (w_wb_rdok & w_is_load) ? w_ld_data : 32'h0000_0000;
         r_wb_err   <= w_wb_err;
      end
   end

   assign MEM_WB_valid        = r_wb_valid;
   assign MEM_WB_RD           = r_wb_rd;
   assign MEM_WB_regwrite_en  = r_wb_rw;
   assign MEM_WB_wb_sel       = r_wb_sel;
   assign MEM_WB_ALU_OUT      = r_wb_alu;
   assign MEM_WB_LOAD_ALU_OUT = r_wb_ld;
   assign MEM_WB_err          = r_wb_err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

   logic        clk;
   logic        rst;
   logic        EX_MEM_valid;
   logic [31:0] EX_MEM_ALU_OUT;
   logic [31:0] EX_MEM_writedata;
   logic [4:0]  EX_MEM_RD;
   logic [2:0]  EX_MEM_funct3;
   logic        EX_MEM_memwrite_en;
   logic        EX_MEM_regwrite_en;
   logic        EX_MEM_wb_sel;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        MEM_WB_valid;
   logic [4:0]  MEM_WB_RD;
   logic        MEM_WB_regwrite_en;
   logic        MEM_WB_wb_sel;
   logic [31:0] MEM_WB_ALU_OUT;
   logic [31:0] MEM_WB_LOAD_ALU_OUT;
   logic        MEM_WB_err;

   mem_stage_lsu #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .EX_MEM_valid        (EX_MEM_valid),
      .EX_MEM_ALU_OUT      (EX_MEM_ALU_OUT),
      .EX_MEM_writedata    (EX_MEM_writedata),
      .EX_MEM_RD           (EX_MEM_RD),
      .EX_MEM_funct3       (EX_MEM_funct3),
      .EX_MEM_memwrite_en  (EX_MEM_memwrite_en),
      .EX_MEM_regwrite_en  (EX_MEM_regwrite_en),
      .EX_MEM_wb_sel       (EX_MEM_wb_sel),
      .mem_stall           (mem_stall),
      .dmem_req            (dmem_req),
      .dmem_we             (dmem_we),
      .dmem_addr           (dmem_addr),
      .dmem_be             (dmem_be),
      .dmem_wdata          (dmem_wdata),
      .dmem_rdata          (dmem_rdata),
      .dmem_ack            (dmem_ack),
      .MEM_WB_valid        (MEM_WB_valid),
      .MEM_WB_RD           (MEM_WB_RD),
      .MEM_WB_regwrite_en  (MEM_WB_regwrite_en),
      .MEM_WB_wb_sel       (MEM_WB_wb_sel),
      .MEM_WB_ALU_OUT      (MEM_WB_ALU_OUT),
      .MEM_WB_LOAD_ALU_OUT (MEM_WB_LOAD_ALU_OUT),
      .MEM_WB_err          (MEM_WB_err)
   );

   typedef struct {
      logic [4:0]  rd;
      logic        rw;
      logic        sel;
      logic [31:0] alu;
      logic [31:0] ld;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   failures;

   int          ack_delay;
   logic [31:0] rd_word;
   logic        late_ack;
   int          req_age;
   bit          acked;

   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Bus responder: acks the ack_delay-th cycle of each request (0 = first).
   initial begin
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      req_age    = 0;
      acked      = 0;
      forever begin
         @(negedge clk);
         dmem_ack = late_ack;
         if (dmem_req === 1'b1) begin
            if (!acked && ack_delay >= 0 && req_age == ack_delay) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rd_word;
               acked      = 1;
            end
            req_age++;
         end else begin
            req_age = 0;
            acked   = 0;
         end
      end
   end

   // Scoreboard monitor: every live MEM_WB bundle must match the oldest expectation.
   initial begin : monitor
      exp_t        e;
      logic [71:0] got;
      logic [71:0] want;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && MEM_WB_valid === 1'b1) begin
            got = {MEM_WB_RD, MEM_WB_regwrite_en, MEM_WB_wb_sel,
                   MEM_WB_ALU_OUT, MEM_WB_LOAD_ALU_OUT, MEM_WB_err};
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL mem_wb_unexpected got=%h required=none", got);
            end else begin
               e    = sb.pop_front();
               want = {e.rd, e.rw, e.sel, e.alu, e.ld, e.err};
               if (got !== want) begin
                  failures++;
                  $display("FAIL mem_wb_bundle got=%h required=%h", got, want);
               end
            end
         end
      end
   end

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] w);
      logic [31:0] s;
      s = w >> (8 * lane);
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b010:  return w;
         3'b100:  return {24'h0, s[7:0]};
         3'b101:  return {16'h0, s[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   task automatic expect_wb(input logic [4:0] rd, input logic rw, input logic sel,
                            input logic [31:0] alu, input logic [31:0] ld, input logic err);
      exp_t e;
      e.rd = rd; e.rw = rw; e.sel = sel; e.alu = alu; e.ld = ld; e.err = err;
      sb.push_back(e);
   endtask

   task automatic clear_inputs();
      EX_MEM_valid       = 1'b0;
      EX_MEM_ALU_OUT     = 32'h0;
      EX_MEM_writedata   = 32'h0;
      EX_MEM_RD          = 5'd0;
      EX_MEM_funct3      = 3'b000;
      EX_MEM_memwrite_en = 1'b0;
      EX_MEM_regwrite_en = 1'b0;
      EX_MEM_wb_sel      = 1'b0;
   endtask

   // Presents one instruction (called just after a rising edge), holds it while
   // mem_stall is high, and returns just after the edge that accepts it.
   task automatic run_op(input logic memw, input logic sel, input logic rw,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int dly,
                         output int lat, output int stalls, output int reqs);
      EX_MEM_valid       = 1'b1;
      EX_MEM_memwrite_en = memw;
      EX_MEM_wb_sel      = sel;
      EX_MEM_regwrite_en = rw;
      EX_MEM_funct3      = f3;
      EX_MEM_ALU_OUT     = addr;
      EX_MEM_writedata   = wd;
      EX_MEM_RD          = rd;
      ack_delay          = dly;
      lat = -1; stalls = 0; reqs = 0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk); #2;
         if (mem_stall === 1'b1) stalls++;
         if (dmem_req === 1'b1) begin
            reqs++;
            bus_we = dmem_we; bus_addr = dmem_addr; bus_be = dmem_be; bus_wdata = dmem_wdata;
         end
         if (mem_stall !== 1'b1) begin
            @(posedge clk); #1;
            clear_inputs();
            lat = n + 1;
            break;
         end
      end
      if (lat < 0) begin
         checks++; failures++;
         $display("FAIL run_op_bound got=stall_stuck required=release_within_64");
         clear_inputs();
      end
   endtask

   task automatic test_reset();
      logic [72:0] outs;
      repeat (2) @(negedge clk);
      outs = {mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata[0], MEM_WB_valid,
              MEM_WB_RD, MEM_WB_regwrite_en, MEM_WB_wb_sel, MEM_WB_err, MEM_WB_ALU_OUT[0],
              MEM_WB_LOAD_ALU_OUT[0]};
      checks++;
      if (outs !== '0 || dmem_wdata !== 32'h0 || MEM_WB_ALU_OUT !== 32'h0
          || MEM_WB_LOAD_ALU_OUT !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0", outs);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({MEM_WB_valid, dmem_req, mem_stall} !== 3'b000) begin
         failures++;
         $display("FAIL reset_release got=%b required=000", {MEM_WB_valid, dmem_req, mem_stall});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alu_op();
      int lat, st, rq;
      expect_wb(5'd5, 1'b1, 1'b0, 32'h1234, 32'h0, 1'b0);
      run_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h1234, 32'h0, 5'd5, 0, lat, st, rq);
      checks++;
      if (lat != 1 || st != 0 || rq != 0) begin
         failures++;
         $display("FAIL alu_op_timing got=lat%0d/stall%0d/req%0d required=lat1/stall0/req0", lat, st, rq);
      end
      @(negedge clk);
      checks++;
      if (MEM_WB_valid !== 1'b1) begin
         failures++;
         $display("FAIL alu_op_valid got=%b required=1", MEM_WB_valid);
      end
      @(negedge clk);
      checks++;
      if (MEM_WB_valid !== 1'b0 || MEM_WB_regwrite_en !== 1'b0) begin
         failures++;
         $display("FAIL bubble got=v%b/rw%b required=v0/rw0", MEM_WB_valid, MEM_WB_regwrite_en);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load_byte();
      int lat, st, rq;
      rd_word = 32'h80FF_0000;
      expect_wb(5'd7, 1'b1, 1'b1, 32'h103, 32'hFFFF_FF80, 1'b0);
      run_op(1'b0, 1'b1, 1'b1, 3'b000, 32'h103, 32'h0, 5'd7, 3, lat, st, rq);
      checks++;
      if (lat != 5 || st != 4 || rq != 4) begin
         failures++;
         $display("FAIL lb_timing got=lat%0d/stall%0d/req%0d required=lat5/stall4/req4", lat, st, rq);
      end
      checks++;
      if (bus_addr !== 32'h100 || bus_be !== 4'b1000 || bus_we !== 1'b0) begin
         failures++;
         $display("FAIL lb_bus got=addr%h/be%b/we%b required=addr00000100/be1000/we0",
                  bus_addr, bus_be, bus_we);
      end
   endtask

   task automatic test_store_half();
      int lat, st, rq;
      expect_wb(5'd3, 1'b0, 1'b0, 32'h202, 32'h0, 1'b0);
      run_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD_1234, 5'd3, 0, lat, st, rq);
      checks++;
      if (bus_we !== 1'b1 || bus_be !== 4'b1100 || bus_wdata !== 32'h1234_1234
          || bus_addr !== 32'h200) begin
         failures++;
         $display("FAIL sh_bus got=we%b/be%b/wd%h/a%h required=we1/be1100/wd12341234/a00000200",
                  bus_we, bus_be, bus_wdata, bus_addr);
      end
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL sh_latency got=%0d required=2", lat);
      end
   endtask

   task automatic test_misaligned();
      int lat, st, rq;
      expect_wb(5'd8, 1'b0, 1'b1, 32'h101, 32'h0, 1'b1);
      run_op(1'b0, 1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 5'd8, 0, lat, st, rq);
      checks++;
      if (lat != 1 || st != 0 || rq != 0) begin
         failures++;
         $display("FAIL lw_misaligned got=lat%0d/stall%0d/req%0d required=lat1/stall0/req0", lat, st, rq);
      end
   endtask

   task automatic test_illegal();
      int lat, st, rq;
      expect_wb(5'd14, 1'b0, 1'b0, 32'h500, 32'h0, 1'b1);
      run_op(1'b1, 1'b0, 1'b1, 3'b011, 32'h500, 32'h1, 5'd14, 0, lat, st, rq);
      checks++;
      if (rq != 0 || lat != 1) begin
         failures++;
         $display("FAIL store_illegal got=req%0d/lat%0d required=req0/lat1", rq, lat);
      end
      expect_wb(5'd15, 1'b0, 1'b1, 32'h504, 32'h0, 1'b1);
      run_op(1'b0, 1'b1, 1'b1, 3'b110, 32'h504, 32'h0, 5'd15, 0, lat, st, rq);
      checks++;
      if (rq != 0 || lat != 1) begin
         failures++;
         $display("FAIL load_illegal got=req%0d/lat%0d required=req0/lat1", rq, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3s[4]   = '{3'b010, 3'b100, 3'b001, 3'b000};
      logic [31:0] addrs[4] = '{32'h400, 32'h401, 32'h402, 32'h403};
      logic [31:0] words[4] = '{32'hDEAD_BEEF, 32'h0000_8000, 32'h8001_0000, 32'h0};
      logic        stores[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int          dlys[4]  = '{1, 2, 0, 1};
      int lat, st, rq;
      for (int i = 0; i < 4; i++) begin
         rd_word = words[i];
         expect_wb(5'(10 + i), !stores[i], !stores[i], addrs[i],
                   stores[i] ? 32'h0 : model_load(f3s[i], addrs[i][1:0], words[i]), 1'b0);
         run_op(stores[i], !stores[i], 1'b1, f3s[i], addrs[i], 32'h0000_0055, 5'(10 + i),
                dlys[i], lat, st, rq);
         checks++;
         if (lat != 2 + dlys[i]) begin
            failures++;
            $display("FAIL b2b_latency op%0d got=%0d required=%0d", i, lat, 2 + dlys[i]);
         end
      end
      checks++;
      if (bus_be !== 4'b1000 || bus_wdata !== 32'h5555_5555 || bus_we !== 1'b1) begin
         failures++;
         $display("FAIL sb_bus got=be%b/wd%h/we%b required=be1000/wd55555555/we1",
                  bus_be, bus_wdata, bus_we);
      end
   endtask

   task automatic test_timeout();
      int lat, st, rq;
      expect_wb(5'd9, 1'b0, 1'b1, 32'h302, 32'h0, 1'b1);
      run_op(1'b0, 1'b1, 1'b1, 3'b101, 32'h302, 32'h0, 5'd9, -1, lat, st, rq);
      checks++;
      if (rq != 16 || st != 16 || lat != 17) begin
         failures++;
         $display("FAIL timeout_timing got=req%0d/stall%0d/lat%0d required=req16/stall16/lat17", rq, st, lat);
      end
      checks++;
      if (dmem_req !== 1'b0) begin
         failures++;
         $display("FAIL timeout_req_drop got=%b required=0", dmem_req);
      end
   endtask

   task automatic test_reset_mid_access();
      int bad_cyc;
      ack_delay          = -1;
      EX_MEM_valid       = 1'b1;
      EX_MEM_wb_sel      = 1'b1;
      EX_MEM_regwrite_en = 1'b1;
      EX_MEM_funct3      = 3'b101;
      EX_MEM_ALU_OUT     = 32'h302;
      EX_MEM_RD          = 5'd9;
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if (dmem_req !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre_req got=%b required=1", dmem_req);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({dmem_req, mem_stall, MEM_WB_valid, dmem_be} !== 7'b0) begin
         failures++;
         $display("FAIL rst_mid_async got=%b required=0000000",
                  {dmem_req, mem_stall, MEM_WB_valid, dmem_be});
      end
      clear_inputs();
      @(posedge clk); #1;
      rst      = 1'b1;
      late_ack = 1'b1;
      @(posedge clk); #1;
      late_ack = 1'b0;
      bad_cyc  = 0;
      repeat (4) begin
         @(negedge clk); #2;
         if (MEM_WB_valid !== 1'b0 || dmem_req !== 1'b0) bad_cyc++;
      end
      checks++;
      if (bad_cyc != 0) begin
         failures++;
         $display("FAIL rst_late_ack got=%0d_bad_cycles required=0", bad_cyc);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      ack_delay = -1;
      rd_word   = 32'h0;
      late_ack  = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 32'h0;
      bus_be    = 4'h0;
      bus_wdata = 32'h0;
      clear_inputs();

      test_reset();
      test_alu_op();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_illegal();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drained got=%0d_pending required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
